// File: rtl/window_3x3_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | window_3x3_gen: raster pixel stream -> sliding 3x3 neighbourhood window   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module window_3x3_gen #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    input  logic [DATA_WIDTH-1:0]         i_data,
    output logic                          o_valid,
    output logic [9*DATA_WIDTH-1:0]       o_window,
    output logic [$clog2(IMG_WIDTH)-1:0]  o_col,
    output logic [$clog2(IMG_HEIGHT)-1:0] o_row,
    output logic                          o_done
);

    localparam int unsigned c_col_w = $clog2(IMG_WIDTH);
    localparam int unsigned c_row_w = $clog2(IMG_HEIGHT);
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_WIDTH - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_HEIGHT - 1);
    localparam logic [c_col_w-1:0] c_col_two  = c_col_w'(2);
    localparam logic [c_row_w-1:0] c_row_two  = c_row_w'(2);

    // r_lb0 holds the previous line, r_lb1 the line before that
    logic [DATA_WIDTH-1:0] r_lb0 [0:IMG_WIDTH-1];
    logic [DATA_WIDTH-1:0] r_lb1 [0:IMG_WIDTH-1];
    logic [DATA_WIDTH-1:0] r_win [0:8];

    logic [c_col_w-1:0] r_col;
    logic [c_row_w-1:0] r_row;
    logic               r_valid;
    logic               r_done;
    logic [c_col_w-1:0] r_out_col;
    logic [c_row_w-1:0] r_out_row;

    logic [DATA_WIDTH-1:0] w_top;
    logic [DATA_WIDTH-1:0] w_mid;
    logic                  w_accept;
    logic                  w_complete;
    logic                  w_col_end;
    logic                  w_row_end;

    assign w_accept   = i_valid;
    assign w_top      = r_lb1[r_col];
    assign w_mid      = r_lb0[r_col];
    assign w_col_end  = (r_col == c_col_last);
    assign w_row_end  = (r_row == c_row_last);
    assign w_complete = w_accept && (r_row >= c_row_two) && (r_col >= c_col_two);

    // Line-buffer RAM is never reset; rows 0/1 of a frame emit no window, masking stale data
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_lb1[r_col] <= w_mid;
            r_lb0[r_col] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col     <= '0;
            r_row     <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_out_col <= '0;
            r_out_row <= '0;
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
        end else begin
            r_valid <= w_complete;
            r_done  <= w_complete && w_col_end && w_row_end;
            if (w_complete) begin
                r_out_col <= r_col - c_col_w'(1);
                r_out_row <= r_row - c_row_w'(1);
            end
            if (w_accept) begin
                for (int i = 0; i < 3; i++) begin
                    r_win[3*i]   <= r_win[3*i+1];
                    r_win[3*i+1] <= r_win[3*i+2];
                end
                r_win[2] <= w_top;
                r_win[5] <= w_mid;
                r_win[8] <= i_data;
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_row_end ? '0 : r_row + c_row_w'(1);
                end else begin
                    r_col <= r_col + c_col_w'(1);
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < 9; k++) begin : g_pack
            assign o_window[k*DATA_WIDTH +: DATA_WIDTH] = r_win[k];
        end
    endgenerate

    assign o_valid = r_valid;
    assign o_done  = r_done;
    assign o_col   = r_out_col;
    assign o_row   = r_out_row;

endmodule
`default_nettype wire
